// File: rtl/reg_dump_streamer.sv
// reg_dump_streamer: walks the register file and streams a HEADER/PC/regs/checksum frame over valid/ready.
module reg_dump_streamer #(
  parameter int          NUM_REGS = 32,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] pc_in,
  output logic [4:0]  rd_idx,
  input  logic [31:0] rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, HDR, LOAD, BYTE, CSUM} state_t;
  localparam logic [5:0] LAST_WORD = 6'(NUM_REGS);
  state_t      state_q, state_d;
  logic [31:0] pc_q, shift_q;
  logic [7:0]  csum_q;
  logic [5:0]  word_q;
  logic [1:0]  byte_q;
  logic [4:0]  rd_idx_q;
  logic        done_q;
  logic        xfer;
  assign xfer = tx_valid && tx_ready;
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? HDR : IDLE;
      HDR:     state_d = xfer ? LOAD : HDR;
      LOAD:    state_d = BYTE;
      BYTE:    state_d = (xfer && byte_q == 2'd3) ? (word_q == LAST_WORD ? CSUM : LOAD) : BYTE;
      CSUM:    state_d = xfer ? IDLE : CSUM;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    tx_valid = state_q == HDR || state_q == BYTE || state_q == CSUM;
    tx_data  = state_q == HDR ? HEADER : state_q == BYTE ? shift_q[7:0] : state_q == CSUM ? csum_q : 8'h00;
    busy     = state_q != IDLE;
    done     = done_q;
    rd_idx   = rd_idx_q;
  end
  // rd_idx moves to the next register on the edge into LOAD so rd_data is settled during LOAD
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      shift_q  <= '0;
      csum_q   <= '0;
      word_q   <= '0;
      byte_q   <= '0;
      rd_idx_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= state_q == CSUM && xfer;
      if (state_q == IDLE && start) begin
        pc_q   <= pc_in;
        csum_q <= '0;
      end
      if (state_q == HDR && xfer) word_q <= '0;
      if (state_q == LOAD) begin
        shift_q <= word_q == 6'd0 ? pc_q : rd_data;
        byte_q  <= '0;
      end
      if (state_q == BYTE && xfer) begin
        csum_q  <= csum_q + shift_q[7:0];
        shift_q <= shift_q >> 8;
        byte_q  <= byte_q + 2'd1;
        if (byte_q == 2'd3 && word_q != LAST_WORD) begin
          word_q   <= word_q + 6'd1;
          rd_idx_q <= word_q[4:0];
        end
      end
    end
  end
endmodule
